// File: rtl/instr_pack.sv
// Shared constants and types for the 9-bit CPU: sequencer state encoding
// and the table of subroutine entry points reached by jtsr.
package instr_pack;
    localparam int SEQ_PC_W  = 10;
    localparam int SEQ_TGT_W = 8;
    localparam int SEQ_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} seq_state_t;

    // Subroutine entry points indexed by the jtsr immediate; unallocated slots are 0.
    localparam logic [SEQ_PC_W-1:0] SUB_ADDR [16] = '{
        10'd100, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
        10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0
    };
endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses. Only the stack pointer is reset or cleared;
// the storage keeps its contents. Overflowing pushes and underflowing pops
// are silently dropped; the sequencer turns them into a fault.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             we;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign wr_idx  = IDX_W'(sp_q);
    assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
    assign top_o   = mem_q[rd_idx];

    // Pointer update: clear wins, then pop, then push; illegal ops are no-ops.
    always_comb begin
        sp_d = sp_q;
        we   = 1'b0;
        if (clear_i) begin
            sp_d = '0;
        end else if (pop_i) begin
            if (!empty_o) sp_d = sp_q - SP_W'(1);
        end else if (push_i && !full_o) begin
            sp_d = sp_q + SP_W'(1);
            we   = 1'b1;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sp_q <= '0;
        else       sp_q <= sp_d;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_idx] <= push_data_i;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow sequencer. Chooses the next pc each cycle
// from the decoder strobes for the instruction currently addressed by pc.
module pc_sequencer
    import instr_pack::*;
#(
    parameter int PC_W  = SEQ_PC_W,
    parameter int TGT_W = SEQ_TGT_W,
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             br_taken,
    input  logic [TGT_W-1:0] br_target,
    input  logic             call_en,
    input  logic [3:0]       call_idx,
    input  logic             ret_en,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             stack_err
);
    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
    logic            push, pop, clear, full, empty;
    logic            running_q, done_q, stack_err_q;

    assign pc_inc = pc_q + PC_W'(1);

    return_stack #(.DEPTH(DEPTH), .W(PC_W)) u_stack (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear),
        .push_i     (push),
        .pop_i      (pop),
        .push_data_i(pc_inc),
        .top_o      (ret_addr),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Next state and next pc; priority halt > ret > call > branch > increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (ret_en) begin
                    if (empty) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = ret_addr;
                        pop  = 1'b1;
                    end
                end else if (call_en) begin
                    if (full) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = PC_W'(SUB_ADDR[call_idx]);
                        push = 1'b1;
                    end
                end else if (br_taken) begin
                    pc_d = {{(PC_W-TGT_W){1'b0}}, br_target};
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                // IDLE, HALT, FAULT: only start matters, and it restarts at 0.
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    clear   = 1'b1;
                end
            end
        endcase
    end

    // State, pc and registered status decodes share one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            running_q   <= (state_d == RUN);
            done_q      <= (state_d == HALT);
            stack_err_q <= (state_d == FAULT);
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign stack_err = stack_err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues the expected post-edge
// outputs for each cycle of stimulus; the monitor pops and compares on negedge.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, halt_req, br_taken, call_en, ret_en;
    logic [7:0] br_target;
    logic [3:0] call_idx;
    logic [9:0] pc;
    logic       running, done, stack_err;

    typedef struct {
        logic [9:0] pc;
        logic       run;
        logic       dn;
        logic       err;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt_req (halt_req),
        .br_taken (br_taken),
        .br_target(br_target),
        .call_en  (call_en),
        .call_idx (call_idx),
        .ret_en   (ret_en),
        .pc       (pc),
        .running  (running),
        .done     (done),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock of stimulus.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if (pc !== mon_e.pc || running !== mon_e.run || done !== mon_e.dn ||
                stack_err !== mon_e.err) begin
                bad++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b, want pc=%0d run=%b done=%b err=%b",
                         mon_e.nm, pc, running, done, stack_err,
                         mon_e.pc, mon_e.run, mon_e.dn, mon_e.err);
            end
        end
    end

    task automatic drv(input logic s, h, b, input logic [7:0] t, input logic c,
                       input logic [3:0] ci, input logic r, input logic [9:0] epc,
                       input logic er, ed, ee, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        start = s; halt_req = h; br_taken = b; br_target = t;
        call_en = c; call_idx = ci; ret_en = r;
        e.pc = epc; e.run = er; e.dn = ed; e.err = ee; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic nop(input logic [9:0] epc, input string nm);
        drv(0, 0, 0, 8'd0, 0, 4'd0, 0, epc, 1, 0, 0, nm);
    endtask

    task automatic br(input logic [7:0] t, input string nm);
        drv(0, 0, 1, t, 0, 4'd0, 0, {2'b00, t}, 1, 0, 0, nm);
    endtask

    task automatic call(input logic [9:0] epc, input string nm);
        drv(0, 0, 0, 8'd0, 1, 4'd0, 0, epc, 1, 0, 0, nm);
    endtask

    task automatic ret(input logic [9:0] epc, input string nm);
        drv(0, 0, 0, 8'd0, 0, 4'd0, 1, epc, 1, 0, 0, nm);
    endtask

    task automatic go(input string nm);
        drv(1, 0, 0, 8'd0, 0, 4'd0, 0, 10'd0, 1, 0, 0, nm);
    endtask

    task automatic direct_chk(input string nm);
        total++;
        if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || stack_err !== 1'b0) begin
            bad++;
            $display("FAIL %s: got pc=%0d run=%b done=%b err=%b, want all zero",
                     nm, pc, running, done, stack_err);
        end
    endtask

    initial begin
        reset = 1'b1; start = 0; halt_req = 0; br_taken = 0; br_target = 0;
        call_en = 0; call_idx = 0; ret_en = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        direct_chk("reset_vals");

        // Reset mid-run at pc=37.
        go("start_idle");
        br(8'd37, "br_37");
        @(negedge clk);
        #1 reset = 1'b1;
        #1 direct_chk("async_reset");
        @(negedge clk);
        #1 reset = 1'b0;
        drv(0, 0, 1, 8'd5, 1, 4'd0, 1, 10'd0, 0, 0, 0, "idle_ignores");
        go("start");
        nop(10'd1, "inc1");
        nop(10'd2, "inc2");
        nop(10'd3, "inc3");

        // Branch taken / not taken.
        br(8'd96, "br_96");
        br(8'd9, "br_taken_9");
        br(8'd96, "br_96b");
        nop(10'd97, "br_not_taken");

        // Call/return, then underflow fault.
        br(8'd44, "br_44");
        call(10'd100, "call_44");
        br(8'd112, "br_112");
        ret(10'd45, "ret_45");
        drv(0, 0, 0, 8'd0, 0, 4'd0, 1, 10'd45, 0, 0, 1, "ret_empty_fault");
        drv(0, 0, 1, 8'd3, 0, 4'd0, 0, 10'd45, 0, 0, 1, "fault_ignores");
        go("fault_restart");

        // Four nested calls, LIFO unwind, then underflow.
        call(10'd100, "nest_c1");
        br(8'd10, "nest_b10");
        call(10'd100, "nest_c2");
        br(8'd20, "nest_b20");
        call(10'd100, "nest_c3");
        br(8'd30, "nest_b30");
        call(10'd100, "nest_c4");
        ret(10'd31, "unwind_31");
        ret(10'd21, "unwind_21");
        ret(10'd11, "unwind_11");
        ret(10'd1, "unwind_1");
        drv(0, 0, 0, 8'd0, 0, 4'd0, 1, 10'd1, 0, 0, 1, "underflow");
        go("restart_u");

        // Overflow: fifth call faults with pc frozen.
        call(10'd100, "ov_c1");
        call(10'd100, "ov_c2");
        call(10'd100, "ov_c3");
        call(10'd100, "ov_c4");
        drv(0, 0, 0, 8'd0, 1, 4'd0, 0, 10'd100, 0, 0, 1, "overflow");
        drv(0, 0, 1, 8'd7, 0, 4'd0, 0, 10'd100, 0, 0, 1, "overflow_frozen");
        go("restart_o");

        // Unallocated subroutine slot, and ret > call > branch priority.
        drv(0, 0, 0, 8'd0, 1, 4'd5, 0, 10'd0, 1, 0, 0, "call_idx5");
        drv(0, 0, 1, 8'd7, 1, 4'd0, 1, 10'd1, 1, 0, 0, "prio_ret");
        drv(1, 0, 0, 8'd0, 0, 4'd0, 0, 10'd2, 1, 0, 0, "start_in_run");

        // Halt.
        br(8'd97, "br_97");
        drv(0, 1, 0, 8'd0, 0, 4'd0, 0, 10'd97, 0, 1, 0, "halt_97");
        drv(0, 0, 1, 8'd4, 1, 4'd0, 1, 10'd97, 0, 1, 0, "halt_ignores");
        go("halt_restart");
        br(8'd50, "br_50");
        drv(0, 1, 1, 8'd9, 0, 4'd0, 1, 10'd50, 0, 1, 0, "halt_prio");
        go("halt_restart2");

        // Wrap-around.
        br(8'd255, "br_255");
        for (int i = 256; i <= 1023; i++) nop(10'(i), "inc_up");
        nop(10'd0, "wrap_0");
        br(8'd255, "br_255b");
        for (int i = 256; i <= 1023; i++) nop(10'(i), "inc_up2");
        call(10'd100, "call_1023");
        ret(10'd0, "ret_wrap_0");

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
